// File: rtl/register_file_pkg.sv
// Shared CPU definitions used by the register file: default widths and the
// architectural zero register index.
package register_file_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_ZERO   = 0;

endpackage : register_file_pkg

// File: rtl/register_file_if.sv
// Decode-stage register file port bundle: two read ports driven by rs/rt and
// one write port driven by writeback.
interface register_file_if
  import register_file_pkg::*;
#(
  parameter int DATA_W = REG_W,
  parameter int ADDR_W = REG_ADDR_W
);

  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;

  modport master (
    output raddr1, raddr2, we, waddr, wdata,
    input  rdata1, rdata2
  );

  modport slave (
    input  raddr1, raddr2, we, waddr, wdata,
    output rdata1, rdata2
  );

endinterface : register_file_if

// File: rtl/register_file.sv
// MIPS general-purpose register file: 2**ADDR_W x DATA_W flops, two
// combinational read ports, one synchronous write port, r0 hardwired to zero.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W = REG_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic            clk,
  input  logic            rst_n,
  register_file_if.slave  rf
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // NOTE: regs_d starts as a full copy of regs_q so every element is assigned
  // on every path; a missing default here would infer latches.
  always_comb begin
    regs_d = regs_q;
    if (rf.we && (rf.waddr != ADDR_W'(REG_ZERO))) begin
      regs_d[rf.waddr] = rf.wdata;
    end
    regs_d[REG_ZERO] = '0;
  end

  // NOTE: this storage must be flops with an asynchronous clear, not a RAM;
  // the reset branch clears every entry at once, which a memory macro can't.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // No write bypass: reads always see the stored value.
  assign rf.rdata1 = (rf.raddr1 == ADDR_W'(REG_ZERO)) ? '0 : regs_q[rf.raddr1];
  assign rf.rdata2 = (rf.raddr2 == ADDR_W'(REG_ZERO)) ? '0 : regs_q[rf.raddr2];

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus random
// traffic, with expected read values queued to a decoupled monitor.
module tb_register_file;
  import register_file_pkg::*;

  localparam int DW = REG_W;
  localparam int AW = REG_ADDR_W;
  localparam int NR = 2 ** AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  register_file_if #(.DATA_W(DW), .ADDR_W(AW)) rf ();

  register_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rf.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } exp_t;

  exp_t          exp_q[$];
  event          sample_ev;
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] model [NR];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: whenever a sample is presented, pop the oldest expectation.
  initial begin
    forever begin
      @(sample_ev);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got empty queue expected an entry");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("%s.rdata1[r%0d]", e.name, e.a1), rf.rdata1, e.e1);
        check($sformatf("%s.rdata2[r%0d]", e.name, e.a2), rf.rdata2, e.e2);
      end
    end
  end

  function automatic logic [DW-1:0] ref_read(input int a);
    return (a == 0 || !rst_n) ? '0 : model[a];
  endfunction

  task automatic sample(input string name, input int a1, input int a2);
    exp_t e;
    rf.raddr1 = AW'(a1);
    rf.raddr2 = AW'(a2);
    #1;
    e.name = name;
    e.a1   = AW'(a1);
    e.a2   = AW'(a2);
    e.e1   = ref_read(a1);
    e.e2   = ref_read(a2);
    exp_q.push_back(e);
    -> sample_ev;
    #1;
  endtask

  task automatic drive_write(input logic w, input int a, input logic [DW-1:0] d);
    @(negedge clk);
    rf.we    = w;
    rf.waddr = AW'(a);
    rf.wdata = d;
  endtask

  // Commit the edge to the model using the spec rules, then idle the port.
  task automatic tick();
    @(posedge clk);
    if (rf.we && rst_n && rf.waddr != 0) model[rf.waddr] = rf.wdata;
    #1;
    rf.we = 1'b0;
  endtask

  task automatic do_reset_assert();
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;
  endtask

  initial begin
    rf.raddr1 = '0;
    rf.raddr2 = '0;
    rf.we     = 1'b0;
    rf.waddr  = '0;
    rf.wdata  = '0;
    do_reset_assert();
    #12;
    sample("por", 5, 31);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write/read sequence.
    drive_write(1'b1, 16, 32'd1337);
    rf.raddr1 = 5'd16;
    tick();
    sample("basic_e1", 16, 9);
    drive_write(1'b1, 9, 32'd69);
    tick();
    sample("basic_e2", 16, 9);

    // Zero register ignores writes.
    drive_write(1'b1, 0, 32'hFFFF_FFFF);
    tick();
    sample("zero_reg", 0, 0);

    // Write enable low.
    drive_write(1'b0, 3, 32'd42);
    tick();
    sample("we_off", 3, 16);

    // No bypass: old value before the edge, new value after.
    drive_write(1'b1, 7, 32'd100);
    sample("no_bypass_pre", 7, 7);
    tick();
    sample("no_bypass_post", 7, 7);

    // Back-to-back writes to the same register.
    drive_write(1'b1, 12, 32'hAAAA_0001);
    tick();
    drive_write(1'b1, 12, 32'h5555_0002);
    tick();
    sample("b2b", 12, 12);

    // Async reset mid-cycle after writing r5.
    drive_write(1'b1, 5, 32'hDEAD_BEEF);
    tick();
    sample("pre_reset", 5, 16);
    #1;
    do_reset_assert();
    sample("async_reset", 5, 16);
    drive_write(1'b1, 8, 32'h1234_5678);
    tick();
    for (int i = 0; i < NR; i++) sample("in_reset", i, NR - 1 - i);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < NR; i++) sample("post_reset", i, NR - 1 - i);

    // Full sweep, dual-port read of (i, 31-i).
    for (int i = 1; i < NR; i++) begin
      drive_write(1'b1, i, DW'(i * 3 + 1));
      tick();
    end
    for (int i = 0; i < NR; i++) sample("sweep", i, NR - 1 - i);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      drive_write(1'($urandom_range(0, 1)), int'($urandom_range(0, NR - 1)), $urandom());
      if ($urandom_range(0, 3) == 0)
        sample("rand_pre", int'(rf.waddr), int'($urandom_range(0, NR - 1)));
      tick();
      sample("rand", int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NR - 1)));
    end

    #5;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_register_file
